// File: rtl/ram_arbiter.sv
// Single-port SRAM arbiter: display reads, game read/write, bulk clear.
// The display has priority; the game is forced in after STARVE_LIMIT waits.
module ram_arbiter #(
    parameter int ADDR_WIDTH   = 9,
    parameter int DATA_WIDTH   = 1,
    parameter int DEPTH        = 384,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr_start,
    output logic                  o_clr_busy,
    input  logic                  i_disp_req,
    input  logic [ADDR_WIDTH-1:0] i_disp_addr,
    output logic                  o_disp_gnt,
    output logic                  o_disp_valid,
    output logic [DATA_WIDTH-1:0] o_disp_data,
    input  logic                  i_game_req,
    input  logic                  i_game_we,
    input  logic [ADDR_WIDTH-1:0] i_game_addr,
    input  logic [DATA_WIDTH-1:0] i_game_wdata,
    output logic                  o_game_gnt,
    output logic                  o_game_valid,
    output logic [DATA_WIDTH-1:0] o_game_rdata,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic                  o_ram_write,
    output logic [DATA_WIDTH-1:0] o_ram_wdata,
    input  logic [DATA_WIDTH-1:0] i_ram_data
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [3:0]            LIM  = 4'(STARVE_LIMIT);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    state_t                r_state;
    state_t                w_state_nx;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic [ADDR_WIDTH-1:0] w_clr_addr_nx;
    logic [3:0]            r_starve;
    logic [3:0]            w_starve_nx;
    logic                  r_disp_rd_q;
    logic                  r_game_rd_q;
    logic                  w_disp_gnt;
    logic                  w_game_gnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_clr_addr  <= '0;
            r_starve    <= '0;
            r_disp_rd_q <= 1'b0;
            r_game_rd_q <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_clr_addr  <= w_clr_addr_nx;
            r_starve    <= w_starve_nx;
            r_disp_rd_q <= w_disp_gnt;
            r_game_rd_q <= w_game_gnt && !i_game_we;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_clr_addr_nx = r_clr_addr;
        w_starve_nx   = r_starve;
        w_disp_gnt    = 1'b0;
        w_game_gnt    = 1'b0;
        o_ram_addr    = '0;
        o_ram_write   = 1'b0;
        o_ram_wdata   = i_game_wdata;
        unique case (r_state)
            IDLE: begin
                w_game_gnt = i_game_req && (!i_disp_req || r_starve == LIM);
                w_disp_gnt = i_disp_req && !w_game_gnt;
                if (w_disp_gnt) begin
                    o_ram_addr = i_disp_addr;
                end else if (w_game_gnt) begin
                    o_ram_addr  = i_game_addr;
                    o_ram_write = i_game_we;
                end
                if (w_game_gnt || !i_game_req)
                    w_starve_nx = '0;
                else if (w_disp_gnt && r_starve < LIM)
                    w_starve_nx = r_starve + 4'd1;
                if (i_clr_start) begin
                    w_state_nx    = CLEAR;
                    w_clr_addr_nx = '0;
                    w_starve_nx   = '0;
                end
            end
            CLEAR: begin
                o_ram_addr  = r_clr_addr;
                o_ram_write = 1'b1;
                o_ram_wdata = '0;
                w_starve_nx = '0;
                if (r_clr_addr == LAST)
                    w_state_nx = IDLE;
                else
                    w_clr_addr_nx = r_clr_addr + 1'b1;
            end
        endcase
        // Reset must silence the combinational grants and RAM pins at once.
        if (i_rst) begin
            w_disp_gnt  = 1'b0;
            w_game_gnt  = 1'b0;
            o_ram_addr  = '0;
            o_ram_write = 1'b0;
            o_ram_wdata = '0;
        end
    end

    assign o_clr_busy   = (r_state == CLEAR);
    assign o_disp_gnt   = w_disp_gnt;
    assign o_game_gnt   = w_game_gnt;
    assign o_disp_valid = r_disp_rd_q;
    assign o_game_valid = r_game_rd_q;
    assign o_disp_data  = r_disp_rd_q ? i_ram_data : '0;
    assign o_game_rdata = r_game_rd_q ? i_ram_data : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter against a behavioural memory/arbitration model.
module tb_ram_arbiter;
    localparam int AW = 9;
    localparam int DW = 1;
    localparam int DEPTH = 384;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr_start;
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic          g_req;
    logic          g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    logic          clr_busy;
    logic          disp_gnt;
    logic          disp_valid;
    logic [DW-1:0] disp_data;
    logic          game_gnt;
    logic          game_valid;
    logic [DW-1:0] game_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_write;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_q;
    logic [DW-1:0] sram [512];

    ram_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .STARVE_LIMIT(LIM)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_clr_start(clr_start),
        .o_clr_busy(clr_busy),
        .i_disp_req(d_req), .i_disp_addr(d_addr), .o_disp_gnt(disp_gnt),
        .o_disp_valid(disp_valid), .o_disp_data(disp_data),
        .i_game_req(g_req), .i_game_we(g_we), .i_game_addr(g_addr),
        .i_game_wdata(g_wdata), .o_game_gnt(game_gnt),
        .o_game_valid(game_valid), .o_game_rdata(game_rdata),
        .o_ram_addr(ram_addr), .o_ram_write(ram_write),
        .o_ram_wdata(ram_wdata), .i_ram_data(ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write) sram[ram_addr] <= ram_wdata;
        ram_q <= sram[ram_addr];
    end

    int n_chk = 0;
    int n_pass = 0;

    // model state
    logic [DW-1:0] ref_mem [DEPTH];
    bit            m_clear;
    int            m_idx;
    int            m_wait;
    bit            exp_dv, exp_gv;
    logic [DW-1:0] exp_dd, exp_gd;
    bit            m_dg, m_gg;
    // DUT values seen in the last cycle
    logic          last_gg, last_busy, last_dv, last_gv;
    logic [DW-1:0] last_dd, last_gd;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic m_reset();
        m_clear = 0;
        m_idx = 0;
        m_wait = 0;
        exp_dv = 0;
        exp_gv = 0;
    endtask

    task automatic rst_outs(string tag);
        check({tag, "_dgnt"}, 32'(disp_gnt), 0);
        check({tag, "_ggnt"}, 32'(game_gnt), 0);
        check({tag, "_dval"}, 32'(disp_valid), 0);
        check({tag, "_gval"}, 32'(game_valid), 0);
        check({tag, "_ddat"}, 32'(disp_data), 0);
        check({tag, "_gdat"}, 32'(game_rdata), 0);
        check({tag, "_addr"}, 32'(ram_addr), 0);
        check({tag, "_wr"}, 32'(ram_write), 0);
        check({tag, "_wd"}, 32'(ram_wdata), 0);
        check({tag, "_busy"}, 32'(clr_busy), 0);
    endtask

    task automatic cyc();
        logic [AW-1:0] ea;
        bit            ew;
        logic [DW-1:0] ed;
        #1;
        if (m_clear) begin
            m_dg = 0;
            m_gg = 0;
            ea = AW'(m_idx);
            ew = 1;
            ed = '0;
        end else begin
            m_gg = g_req && (!d_req || m_wait == LIM);
            m_dg = d_req && !m_gg;
            ea = m_dg ? d_addr : (m_gg ? g_addr : '0);
            ew = m_gg && g_we;
            ed = g_wdata;
        end
        check("disp_gnt", 32'(disp_gnt), 32'(m_dg));
        check("game_gnt", 32'(game_gnt), 32'(m_gg));
        check("ram_addr", 32'(ram_addr), 32'(ea));
        check("ram_write", 32'(ram_write), 32'(ew));
        check("ram_wdata", 32'(ram_wdata), 32'(ed));
        check("clr_busy", 32'(clr_busy), 32'(m_clear));
        check("disp_valid", 32'(disp_valid), 32'(exp_dv));
        check("disp_data", 32'(disp_data), exp_dv ? 32'(exp_dd) : 0);
        check("game_valid", 32'(game_valid), 32'(exp_gv));
        check("game_rdata", 32'(game_rdata), exp_gv ? 32'(exp_gd) : 0);
        last_gg = game_gnt;
        last_busy = clr_busy;
        last_dv = disp_valid;
        last_dd = disp_data;
        last_gv = game_valid;
        last_gd = game_rdata;
        @(posedge clk);
        if (m_clear) begin
            ref_mem[m_idx] = '0;
            m_idx++;
            if (m_idx == DEPTH) m_clear = 0;
            exp_dv = 0;
            exp_gv = 0;
        end else begin
            exp_dv = m_dg;
            exp_dd = ref_mem[d_addr];
            exp_gv = m_gg && !g_we;
            exp_gd = ref_mem[g_addr];
            if (m_gg && g_we) ref_mem[g_addr] = g_wdata;
            if (m_gg || !g_req) m_wait = 0;
            else if (m_dg && m_wait < LIM) m_wait++;
            if (clr_start) begin
                m_clear = 1;
                m_idx = 0;
                m_wait = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int w, maxw, ng, nb, n, ones;
        for (int i = 0; i < 512; i++) begin
            logic [8:0] a;
            a = 9'(i);
            sram[i] <= ^a;
            if (i < DEPTH) ref_mem[i] = ^a;
        end
        m_reset();
        rst = 1;
        clr_start = 0;
        d_req = 1; d_addr = 70;
        g_req = 1; g_we = 1; g_addr = 5; g_wdata = 1;
        repeat (2) @(negedge clk);
        #1 rst_outs("reset");
        @(negedge clk);
        rst = 0;
        d_req = 0; g_req = 0; g_we = 0; g_wdata = 0;
        cyc();

        d_req = 1; d_addr = 70;
        cyc();
        d_req = 0;
        cyc();
        check("disp70_valid", 32'(last_dv), 1);
        check("disp70_data", 32'(last_dd), 1);
        check("disp70_gval", 32'(last_gv), 0);

        g_req = 1; g_we = 1; g_addr = 5; g_wdata = 1;
        cyc();
        check("wr5_gnt", 32'(last_gg), 1);
        g_we = 0; g_wdata = 0;
        cyc();
        check("wr5_noval", 32'(last_gv), 0);
        g_req = 0;
        cyc();
        check("rd5_valid", 32'(last_gv), 1);
        check("rd5_data", 32'(last_gd), 1);

        d_req = 1; g_req = 1; g_we = 0;
        w = 0; maxw = 0; ng = 0;
        for (int i = 0; i < 20; i++) begin
            d_addr = AW'($urandom_range(0, DEPTH - 1));
            g_addr = AW'($urandom_range(0, DEPTH - 1));
            cyc();
            if (last_gg) begin
                ng++;
                w = 0;
            end else begin
                w++;
                if (w > maxw) maxw = w;
            end
        end
        check("starve_maxwait", 32'(maxw), LIM);
        check("starve_ngame", 32'(ng), 4);
        d_req = 0; g_req = 0;
        cyc();

        for (int i = 0; i < 400; i++) begin
            if (!d_req) begin
                d_req = 1'($urandom_range(0, 1));
                d_addr = AW'($urandom_range(0, DEPTH - 1));
            end
            if (!g_req) begin
                g_req = 1'($urandom_range(0, 1));
                g_we = 1'($urandom_range(0, 1));
                g_addr = AW'($urandom_range(0, DEPTH - 1));
                g_wdata = DW'($urandom_range(0, 1));
            end
            cyc();
            if (m_dg) d_req = 0;
            if (m_gg) g_req = 0;
        end
        d_req = 0; g_req = 0;
        cyc();

        clr_start = 1;
        cyc();
        clr_start = 0;
        g_req = 1; g_we = 0; g_addr = 7;
        nb = 0; n = 0;
        while (m_clear && n < 1000) begin
            if (n == 50) clr_start = 1;
            else clr_start = 0;
            cyc();
            if (last_busy) nb++;
            n++;
        end
        clr_start = 0;
        check("clr_busy_len", 32'(nb), DEPTH);
        cyc();
        check("clr_pending_game", 32'(last_gg), 1);
        g_req = 0;
        ones = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            d_req = (i < DEPTH);
            d_addr = AW'(i < DEPTH ? i : 0);
            cyc();
            if (last_dv && last_dd != 0) ones++;
        end
        d_req = 0;
        check("clr_all_zero", 32'(ones), 0);

        for (int i = 0; i < 40; i++) begin
            d_addr = AW'($urandom_range(0, DEPTH - 1));
            g_addr = AW'($urandom_range(0, DEPTH - 1));
            g_we = 1; g_wdata = 1;
            g_req = 1'(i % 2);
            d_req = !g_req;
            cyc();
        end
        d_req = 0; g_req = 0; g_we = 0; g_wdata = 0;
        cyc();

        clr_start = 1;
        cyc();
        clr_start = 0;
        repeat (100) cyc();
        rst = 1;
        #1 rst_outs("rst_mid");
        m_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        cyc();
        check("rst_mid_busy", 32'(last_busy), 0);
        for (int i = 0; i < 6; i++) begin
            d_req = 1;
            d_addr = AW'(i < 3 ? 97 + i : 200 + i);
            cyc();
        end
        d_req = 0;
        cyc();

        d_req = 1; d_addr = 70;
        cyc();
        d_req = 0;
        rst = 1;
        #1 check("rst_drop_valid", 32'(disp_valid), 0);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        cyc();

        clr_start = 1; d_req = 1; d_addr = 70;
        cyc();
        check("clr_req_busy0", 32'(last_busy), 0);
        clr_start = 0; d_req = 0;
        cyc();
        check("clr_req_busy1", 32'(last_busy), 1);
        check("clr_req_valid", 32'(last_dv), 1);
        n = 0;
        while (m_clear && n < 1000) begin
            cyc();
            n++;
        end
        check("clr_req_done", 32'(m_clear), 0);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
